key_menu_ctrl: RTL and testbench
================================

Name: key_menu_ctrl

Overview:
Menu/configuration controller for the medicine-kit UI. It consumes the seven single-cycle key-event pulses produced by the key input stage and arbitrates simultaneous presses. A state machine lets the user select a compartment (slot) and edit its dose time (hour/minute). Each confirmed edit is written as a one-cycle write to the dose-schedule register bank.

Parameters:
N_SLOT, 4, number of medicine compartments; slot index width SW = clog2(N_SLOT), minimum 1
TIMEOUT_S, 10, seconds without an accepted key before the menu aborts to IDLE

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
key  input  7  key-event pulses, one clk cycle wide, synchronous to clk; [0]MENU [1]UP [2]DOWN [3]LEFT [4]RIGHT [5]OK [6]CANCEL
sec_tick  input  1  one-cycle 1 Hz strobe
rd_hour  input  5  stored hour of rd_slot, combinationally valid
rd_min  input  6  stored minute of rd_slot, combinationally valid
rd_slot  output  SW  equals cur_slot (combinational)
cfg_we  output  1  schedule write strobe, one cycle
cfg_slot  output  SW  write slot
cfg_hour  output  5  write hour, 0..23
cfg_min  output  6  write minute, 0..59
menu_active  output  1  high whenever state != IDLE
cur_slot  output  SW  selected slot, for display
edit_hour  output  5  working hour, for display
edit_min  output  6  working minute, for display
field  output  2  0 = none, 1 = slot, 2 = hour, 3 = minute (blink select for display)

Behaviour:
- Reset: state IDLE. cur_slot, edit_hour, edit_min, cfg_* and field are 0. cfg_we is 0. menu_active is 0. Timeout counter is 0.
- Arbitration: when several key bits are high in the same cycle, exactly one is accepted, by fixed priority CANCEL > OK > MENU > UP > DOWN > LEFT > RIGHT. The other bits are dropped, not queued.
- An accepted key in cycle n updates state and registers at the end of cycle n, so the change is visible in cycle n+1.
- All outputs except rd_slot are registered.
- IDLE: MENU -> SEL_SLOT and cur_slot = 0. All other keys are ignored.
- SEL_SLOT (field = 1):
  - UP: cur_slot + 1, wrapping N_SLOT-1 -> 0.
  - DOWN: cur_slot - 1, wrapping 0 -> N_SLOT-1.
  - OK: -> EDIT_HOUR, loading edit_hour = rd_hour and edit_min = rd_min. A loaded value out of range (hour > 23 or min > 59) is replaced with 0.
  - CANCEL or MENU: -> IDLE.
  - LEFT/RIGHT: ignored.
- EDIT_HOUR (field = 2):
  - UP: hour + 1, wrapping 23 -> 0.
  - DOWN: hour - 1, wrapping 0 -> 23.
  - RIGHT: -> EDIT_MIN.
  - LEFT and MENU: ignored.
  - OK: -> COMMIT.
  - CANCEL: -> SEL_SLOT, edits discarded.
- EDIT_MIN (field = 3):
  - UP: min + 1, wrapping 59 -> 0.
  - DOWN: min - 1, wrapping 0 -> 59.
  - LEFT: -> EDIT_HOUR.
  - RIGHT and MENU: ignored.
  - OK: -> COMMIT.
  - CANCEL: -> SEL_SLOT, edits discarded.
- COMMIT: cfg_we = 1 for exactly one cycle, with cfg_slot = cur_slot, cfg_hour = edit_hour, cfg_min = edit_min. Next state is SEL_SLOT. Keys arriving during COMMIT are dropped.
- Timeout:
  - The counter increments on sec_tick while state != IDLE.
  - It clears on any accepted key and on entry to IDLE.
  - When the count reaches TIMEOUT_S, the next state is IDLE. No write occurs and edits are discarded.
  - Key and sec_tick in the same cycle: the key wins and the counter clears.
  - COMMIT is never preempted by timeout.
- Reset asserted mid-operation returns immediately (asynchronously) to reset values. No partial write is issued.
- cfg_slot, cfg_hour and cfg_min hold their last written values when cfg_we = 0.

Decomposition:
- Package mk_ui_pkg holds:
  - the state encoding (IDLE, SEL_SLOT, EDIT_HOUR, EDIT_MIN, COMMIT);
  - key bit indices KEY_MENU..KEY_CANCEL;
  - HOUR_MAX = 23 and MIN_MAX = 59;
  - field codes.
- Sub-module key_prio_enc: 7-bit key vector in; one-hot accepted key plus valid out; purely combinational. It is instantiated once.
- Wrap-around increment/decrement is a function in mk_ui_pkg.

Test Plan:
- Reset, then MENU, OK with rd_hour = 8 and rd_min = 30, UP x2, RIGHT, DOWN x31, OK -> one cfg_we pulse with slot 0, hour 10, min 59; state returns to SEL_SLOT.
- Wrap checks: in SEL_SLOT (N_SLOT = 4), DOWN from 0 -> slot 3; hour UP from 23 -> 0; minute DOWN from 0 -> 59; rd_hour = 31 on load -> edit_hour = 0.
- Simultaneous keys: key = 7'b0100010 (OK + UP) in EDIT_HOUR -> COMMIT taken, hour unchanged; key = 7'b1100000 -> CANCEL taken, no cfg_we.
- Timeout: enter EDIT_MIN, apply 10 sec_ticks with no key -> IDLE after the 10th, cfg_we never asserted. Repeat with UP on the cycle of the 9th tick -> menu still active after 10 further ticks are short by one (counter restarts at 0).
- Assert rst while in EDIT_HOUR with edits pending -> all outputs 0 and state IDLE immediately; no cfg_we after release.
- In IDLE, pulse UP/DOWN/OK/CANCEL -> no state change, menu_active stays 0.

Source files
------------

// File: rtl/mk_ui_pkg.sv
// rtl/mk_ui_pkg.sv - shared types, constants and helpers for the medicine-kit menu UI
//
// Contents:
//   state_e    menu state encoding
//   field_e    blink-select field codes for the display
//   KEY_*      bit indices into the 7-bit key-event vector
//   HOUR_MAX   largest legal hour value
//   MIN_MAX    largest legal minute value
//   wrap_step  wrap-around increment/decrement over 0..max_val
package mk_ui_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEL_SLOT  = 3'd1,
    ST_EDIT_HOUR = 3'd2,
    ST_EDIT_MIN  = 3'd3,
    ST_COMMIT    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    FIELD_NONE = 2'd0,
    FIELD_SLOT = 2'd1,
    FIELD_HOUR = 2'd2,
    FIELD_MIN  = 2'd3
  } field_e;

  localparam int N_KEYS     = 7;
  localparam int KEY_MENU   = 0;
  localparam int KEY_UP     = 1;
  localparam int KEY_DOWN   = 2;
  localparam int KEY_LEFT   = 3;
  localparam int KEY_RIGHT  = 4;
  localparam int KEY_OK     = 5;
  localparam int KEY_CANCEL = 6;

  localparam logic [4:0] HOUR_MAX = 5'd23;
  localparam logic [5:0] MIN_MAX  = 6'd59;

  // Step val by one within 0..max_val, wrapping at both ends.
  // An out-of-range val is treated as already past the top.
  function automatic logic [7:0] wrap_step(input logic [7:0] val,
                                           input logic [7:0] max_val,
                                           input logic       up);
    if (up) begin
      return (val >= max_val) ? 8'd0 : val + 8'd1;
    end
    return (val == 8'd0 || val > max_val) ? max_val : val - 8'd1;
  endfunction

endpackage

// File: rtl/key_prio_enc.sv
// rtl/key_prio_enc.sv - fixed-priority selector for simultaneous key events
//
// Purpose: picks exactly one key out of a multi-hot key-event vector.
//   Priority: CANCEL > OK > MENU > UP > DOWN > LEFT > RIGHT. Purely combinational.
// Ports:
//   key_i      [6:0]  raw key-event pulses
//   key_oh_o   [6:0]  one-hot accepted key (all zero when none pressed)
//   key_vld_o         any key accepted
module key_prio_enc
  import mk_ui_pkg::*;
(
  input  logic [N_KEYS-1:0] key_i,
  output logic [N_KEYS-1:0] key_oh_o,
  output logic              key_vld_o
);

  always_comb begin
    key_oh_o = '0;
    if      (key_i[KEY_CANCEL]) key_oh_o[KEY_CANCEL] = 1'b1;
    else if (key_i[KEY_OK])     key_oh_o[KEY_OK]     = 1'b1;
    else if (key_i[KEY_MENU])   key_oh_o[KEY_MENU]   = 1'b1;
    else if (key_i[KEY_UP])     key_oh_o[KEY_UP]     = 1'b1;
    else if (key_i[KEY_DOWN])   key_oh_o[KEY_DOWN]   = 1'b1;
    else if (key_i[KEY_LEFT])   key_oh_o[KEY_LEFT]   = 1'b1;
    else if (key_i[KEY_RIGHT])  key_oh_o[KEY_RIGHT]  = 1'b1;
  end

  assign key_vld_o = |key_i;

endmodule

// File: rtl/key_menu_ctrl.sv
// rtl/key_menu_ctrl.sv - menu FSM for slot selection and dose-time editing
//
// Purpose: accepts arbitrated key events, lets the user pick a compartment and
//   edit its hour/minute, and writes confirmed edits to the schedule bank as a
//   single-cycle strobe. Aborts to IDLE after TIMEOUT_S seconds of inactivity.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   key [6:0]          key-event pulses (MENU,UP,DOWN,LEFT,RIGHT,OK,CANCEL)
//   sec_tick           1 Hz single-cycle strobe
//   rd_hour, rd_min    stored time of rd_slot (combinational read)
//   rd_slot            read address, follows cur_slot
//   cfg_we/slot/hour/min  schedule write port; data holds between writes
//   menu_active        menu is open
//   cur_slot, edit_hour, edit_min, field  display state
module key_menu_ctrl
  import mk_ui_pkg::*;
#(
  parameter  int N_SLOT    = 4,
  parameter  int TIMEOUT_S = 10,
  localparam int SW        = (N_SLOT > 1) ? $clog2(N_SLOT) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [6:0]    key,
  input  logic          sec_tick,
  input  logic [4:0]    rd_hour,
  input  logic [5:0]    rd_min,
  output logic [SW-1:0] rd_slot,
  output logic          cfg_we,
  output logic [SW-1:0] cfg_slot,
  output logic [4:0]    cfg_hour,
  output logic [5:0]    cfg_min,
  output logic          menu_active,
  output logic [SW-1:0] cur_slot,
  output logic [4:0]    edit_hour,
  output logic [5:0]    edit_min,
  output logic [1:0]    field
);

  localparam int TW = $clog2(TIMEOUT_S + 1);
  localparam logic [7:0] SLOT_MAX = 8'(N_SLOT - 1);

  logic [N_KEYS-1:0] key_oh;
  logic              key_vld;

  key_prio_enc u_prio (
    .key_i     (key),
    .key_oh_o  (key_oh),
    .key_vld_o (key_vld)
  );

  state_e        state_q, state_d;
  logic [SW-1:0] cur_slot_q, cur_slot_d;
  logic [4:0]    edit_hour_q, edit_hour_d;
  logic [5:0]    edit_min_q, edit_min_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          cfg_we_q, cfg_we_d;
  logic [SW-1:0] cfg_slot_q, cfg_slot_d;
  logic [4:0]    cfg_hour_q, cfg_hour_d;
  logic [5:0]    cfg_min_q, cfg_min_d;
  logic          menu_active_q, menu_active_d;
  field_e        field_q, field_d;
  logic          key_acc;
  logic          tmo_hit;

  // Keys seen during COMMIT are dropped entirely: no action, no counter clear.
  assign key_acc = key_vld && (state_q != ST_COMMIT);
  assign tmo_hit = (tmo_q == TW'(TIMEOUT_S));

  always_comb begin
    state_d       = state_q;
    cur_slot_d    = cur_slot_q;
    edit_hour_d   = edit_hour_q;
    edit_min_d    = edit_min_q;
    tmo_d         = tmo_q;
    cfg_slot_d    = cfg_slot_q;
    cfg_hour_d    = cfg_hour_q;
    cfg_min_d     = cfg_min_q;
    cfg_we_d      = 1'b0;
    menu_active_d = 1'b0;
    field_d       = FIELD_NONE;

    if (state_q != ST_IDLE) begin
      if (key_acc)       tmo_d = '0;
      else if (sec_tick) tmo_d = tmo_q + 1'b1;
    end

    if (key_acc) begin
      unique case (state_q)
        ST_IDLE: begin
          if (key_oh[KEY_MENU]) begin
            state_d    = ST_SEL_SLOT;
            cur_slot_d = '0;
          end
        end
        ST_SEL_SLOT: begin
          if (key_oh[KEY_UP])
            cur_slot_d = SW'(wrap_step(8'(cur_slot_q), SLOT_MAX, 1'b1));
          else if (key_oh[KEY_DOWN])
            cur_slot_d = SW'(wrap_step(8'(cur_slot_q), SLOT_MAX, 1'b0));
          else if (key_oh[KEY_OK]) begin
            state_d     = ST_EDIT_HOUR;
            edit_hour_d = (rd_hour > HOUR_MAX) ? 5'd0 : rd_hour;
            edit_min_d  = (rd_min > MIN_MAX) ? 6'd0 : rd_min;
          end else if (key_oh[KEY_CANCEL] || key_oh[KEY_MENU])
            state_d = ST_IDLE;
        end
        ST_EDIT_HOUR: begin
          if (key_oh[KEY_UP])
            edit_hour_d = 5'(wrap_step(8'(edit_hour_q), 8'(HOUR_MAX), 1'b1));
          else if (key_oh[KEY_DOWN])
            edit_hour_d = 5'(wrap_step(8'(edit_hour_q), 8'(HOUR_MAX), 1'b0));
          else if (key_oh[KEY_RIGHT])  state_d = ST_EDIT_MIN;
          else if (key_oh[KEY_OK])     state_d = ST_COMMIT;
          else if (key_oh[KEY_CANCEL]) state_d = ST_SEL_SLOT;
        end
        ST_EDIT_MIN: begin
          if (key_oh[KEY_UP])
            edit_min_d = 6'(wrap_step(8'(edit_min_q), 8'(MIN_MAX), 1'b1));
          else if (key_oh[KEY_DOWN])
            edit_min_d = 6'(wrap_step(8'(edit_min_q), 8'(MIN_MAX), 1'b0));
          else if (key_oh[KEY_LEFT])   state_d = ST_EDIT_HOUR;
          else if (key_oh[KEY_OK])     state_d = ST_COMMIT;
          else if (key_oh[KEY_CANCEL]) state_d = ST_SEL_SLOT;
        end
        default: ;
      endcase
    end

    if (state_q == ST_COMMIT) begin
      state_d = ST_SEL_SLOT;
    end else if (tmo_hit && state_q != ST_IDLE) begin
      // Inactivity abort overrides whatever key arrived this cycle.
      state_d = ST_IDLE;
    end

    if (state_d == ST_IDLE) tmo_d = '0;

    // Write data is captured as COMMIT is entered so the strobe and data
    // appear together while state_q == COMMIT.
    if (state_d == ST_COMMIT) begin
      cfg_we_d   = 1'b1;
      cfg_slot_d = cur_slot_q;
      cfg_hour_d = edit_hour_q;
      cfg_min_d  = edit_min_q;
    end

    menu_active_d = (state_d != ST_IDLE);
    unique case (state_d)
      ST_SEL_SLOT:  field_d = FIELD_SLOT;
      ST_EDIT_HOUR: field_d = FIELD_HOUR;
      ST_EDIT_MIN:  field_d = FIELD_MIN;
      default:      field_d = FIELD_NONE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cur_slot_q    <= '0;
      edit_hour_q   <= '0;
      edit_min_q    <= '0;
      tmo_q         <= '0;
      cfg_we_q      <= 1'b0;
      cfg_slot_q    <= '0;
      cfg_hour_q    <= '0;
      cfg_min_q     <= '0;
      menu_active_q <= 1'b0;
      field_q       <= FIELD_NONE;
    end else begin
      state_q       <= state_d;
      cur_slot_q    <= cur_slot_d;
      edit_hour_q   <= edit_hour_d;
      edit_min_q    <= edit_min_d;
      tmo_q         <= tmo_d;
      cfg_we_q      <= cfg_we_d;
      cfg_slot_q    <= cfg_slot_d;
      cfg_hour_q    <= cfg_hour_d;
      cfg_min_q     <= cfg_min_d;
      menu_active_q <= menu_active_d;
      field_q       <= field_d;
    end
  end

  assign rd_slot     = cur_slot_q;
  assign cfg_we      = cfg_we_q;
  assign cfg_slot    = cfg_slot_q;
  assign cfg_hour    = cfg_hour_q;
  assign cfg_min     = cfg_min_q;
  assign menu_active = menu_active_q;
  assign cur_slot    = cur_slot_q;
  assign edit_hour   = edit_hour_q;
  assign edit_min    = edit_min_q;
  assign field       = field_q;

endmodule

// File: tb/tb_key_menu_ctrl.sv
// tb/tb_key_menu_ctrl.sv - directed self-checking bench for key_menu_ctrl
module tb_key_menu_ctrl;

  localparam logic [6:0] K_MENU   = 7'b0000001;
  localparam logic [6:0] K_UP     = 7'b0000010;
  localparam logic [6:0] K_DOWN   = 7'b0000100;
  localparam logic [6:0] K_LEFT   = 7'b0001000;
  localparam logic [6:0] K_RIGHT  = 7'b0010000;
  localparam logic [6:0] K_OK     = 7'b0100000;
  localparam logic [6:0] K_CANCEL = 7'b1000000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] key = '0;
  logic       sec_tick = 1'b0;
  logic [4:0] rd_hour = '0;
  logic [5:0] rd_min = '0;
  logic [1:0] rd_slot;
  logic       cfg_we;
  logic [1:0] cfg_slot;
  logic [4:0] cfg_hour;
  logic [5:0] cfg_min;
  logic       menu_active;
  logic [1:0] cur_slot;
  logic [4:0] edit_hour;
  logic [5:0] edit_min;
  logic [1:0] field;

  int n_chk = 0;
  int n_err = 0;
  int we_cnt = 0;
  int we_base;

  key_menu_ctrl #(.N_SLOT(4), .TIMEOUT_S(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .key         (key),
    .sec_tick    (sec_tick),
    .rd_hour     (rd_hour),
    .rd_min      (rd_min),
    .rd_slot     (rd_slot),
    .cfg_we      (cfg_we),
    .cfg_slot    (cfg_slot),
    .cfg_hour    (cfg_hour),
    .cfg_min     (cfg_min),
    .menu_active (menu_active),
    .cur_slot    (cur_slot),
    .edit_hour   (edit_hour),
    .edit_min    (edit_min),
    .field       (field)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (cfg_we === 1'b1) we_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic press(input logic [6:0] k);
    @(negedge clk) key = k;
    @(negedge clk) key = '0;
  endtask

  task automatic press_n(input logic [6:0] k, input int n);
    for (int i = 0; i < n; i++) press(k);
  endtask

  task automatic tick(input logic [6:0] k);
    @(negedge clk) begin key = k; sec_tick = 1'b1; end
    @(negedge clk) begin key = '0; sec_tick = 1'b0; end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    // Reset values
    idle_cycles(3);
    chk("rst_active", menu_active, 0);
    chk("rst_field", field, 0);
    chk("rst_we", cfg_we, 0);
    chk("rst_cfg_hour", cfg_hour, 0);
    @(negedge clk) rst = 1'b0;
    idle_cycles(2);

    // Main edit flow: 08:30 -> hour 10, minute 59 on slot 0
    press(K_MENU);
    chk("menu_field", field, 1);
    chk("menu_slot", cur_slot, 0);
    rd_hour = 5'd8; rd_min = 6'd30;
    press(K_OK);
    chk("load_field", field, 2);
    chk("load_hour", edit_hour, 8);
    chk("load_min", edit_min, 30);
    press_n(K_UP, 2);
    chk("hour_up2", edit_hour, 10);
    press(K_RIGHT);
    chk("right_field", field, 3);
    press_n(K_DOWN, 31);
    chk("min_down31", edit_min, 59);
    we_base = we_cnt;
    press(K_OK);
    chk("commit_we", cfg_we, 1);
    chk("commit_slot", cfg_slot, 0);
    chk("commit_hour", cfg_hour, 10);
    chk("commit_min", cfg_min, 59);
    idle_cycles(1);
    chk("commit_pulses", we_cnt - we_base, 1);
    chk("post_commit_field", field, 1);
    chk("cfg_hold_hour", cfg_hour, 10);

    // Wrap checks
    press(K_DOWN);
    chk("slot_wrap", cur_slot, 3);
    chk("rd_slot", rd_slot, 3);
    rd_hour = 5'd23; rd_min = 6'd0;
    press(K_OK);
    press(K_UP);
    chk("hour_wrap", edit_hour, 0);
    press(K_RIGHT);
    press(K_DOWN);
    chk("min_wrap", edit_min, 59);
    we_base = we_cnt;
    press(K_CANCEL);
    chk("cancel_field", field, 1);
    rd_hour = 5'd31; rd_min = 6'd45;
    press(K_OK);
    chk("oor_hour", edit_hour, 0);
    chk("ok_min45", edit_min, 45);

    // Simultaneous keys: OK beats UP
    press(7'b0100010);
    chk("sim_commit_we", cfg_we, 1);
    chk("sim_commit_hour", cfg_hour, 0);
    chk("sim_commit_slot", cfg_slot, 3);
    idle_cycles(1);
    rd_hour = 5'd5; rd_min = 6'd60;
    press(K_OK);
    chk("oor_min", edit_min, 0);
    chk("ok_hour5", edit_hour, 5);
    press(7'b1100000);
    idle_cycles(1);
    chk("sim_cancel_field", field, 1);
    chk("sim_pulses", we_cnt - we_base, 1);

    // Timeout from EDIT_MIN
    press(K_OK);
    press(K_RIGHT);
    we_base = we_cnt;
    for (int i = 0; i < 9; i++) tick('0);
    chk("tmo9_active", menu_active, 1);
    tick('0);
    idle_cycles(1);
    chk("tmo10_active", menu_active, 0);
    chk("tmo10_field", field, 0);
    chk("tmo_no_we", we_cnt - we_base, 0);

    // Key on 9th tick restarts the counter
    press(K_MENU);
    press(K_OK);
    press(K_RIGHT);
    for (int i = 0; i < 8; i++) tick('0);
    tick(K_UP);
    chk("tmo_key_min", edit_min, 1);
    for (int i = 0; i < 9; i++) tick('0);
    idle_cycles(1);
    chk("tmo_restart_active", menu_active, 1);
    tick('0);
    idle_cycles(1);
    chk("tmo_restart_idle", menu_active, 0);

    // Asynchronous reset mid-edit
    press(K_MENU);
    press(K_UP);
    rd_hour = 5'd7; rd_min = 6'd15;
    press(K_OK);
    press(K_UP);
    chk("pre_rst_hour", edit_hour, 8);
    we_base = we_cnt;
    #2 rst = 1'b1;
    #1;
    chk("arst_active", menu_active, 0);
    chk("arst_hour", edit_hour, 0);
    chk("arst_slot", cur_slot, 0);
    chk("arst_field", field, 0);
    idle_cycles(2);
    @(negedge clk) rst = 1'b0;
    idle_cycles(3);
    chk("arst_no_we", we_cnt - we_base, 0);

    // IDLE ignores everything but MENU
    press(K_UP);
    chk("idle_up", menu_active, 0);
    press(K_DOWN);
    chk("idle_down", menu_active, 0);
    press(K_OK);
    chk("idle_ok", menu_active, 0);
    press(K_CANCEL);
    chk("idle_cancel", menu_active, 0);
    chk("idle_pulses", we_cnt - we_base, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
